// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC owner, single-outstanding imem fetch,
// one-entry output buffer feeding IF/ID, with stall and redirect handling.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus4_if,
  output logic        instr_valid_if
);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        consume;

  assign consume = buf_valid_q & ~stall & ~redirect;

  assign imem_req_valid = (state_q == S_REQ)
                        & (~buf_valid_q | consume)
                        & ~redirect & clear;
  assign imem_req_addr  = pc_q;

  assign instr_if       = buf_valid_q ? buf_instr_q : NOP_INSTR;
  assign pc_if          = buf_pc_q;
  assign pc_plus4_if    = buf_pc_q + 32'd4;
  assign instr_valid_if = buf_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (redirect) begin
      // A redirect outranks stall and any response landing this cycle
      pc_d        = redirect_pc;
      buf_valid_d = 1'b0;
      if (state_q == S_WAIT) begin
        if (imem_resp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end else begin
          kill_d  = 1'b1;
        end
      end
    end else begin
      if (consume) buf_valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              buf_valid_d = 1'b1;
              buf_instr_d = imem_resp_data;
              buf_pc_d    = pc_q;
              pc_d        = pc_q + 32'd4;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage. Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with a separate response channel. Holds each returned instruction in a one-entry output buffer that drives the IF/ID pipeline register inputs. Honours pipeline stalls from the hazard unit and PC redirects (taken branch/jump) from EX, squashing stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven when no valid instruction

Ports:
clk  in  1  clock, all state updates on rising edge
clear  in  1  synchronous active-low reset
stall  in  1  IF/ID hold (IF/ID enable low); buffer must not be consumed
redirect  in  1  taken branch/jump from EX; flush and reload PC
redirect_pc  in  32  target PC when redirect=1
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch address (word-aligned)
imem_req_ready  in  1  memory accepts request this cycle
imem_resp_valid  in  1  fetch data valid (no backpressure)
imem_resp_data  in  32  fetched instruction
instr_if  out  32  instruction to IF/ID (NOP_INSTR when invalid)
pc_if  out  32  PC of instr_if
pc_plus4_if  out  32  pc_if + 4, modulo 2^32
instr_valid_if  out  1  buffer holds a real instruction

Behaviour:
- State: pc_q (next fetch PC), FSM {REQ, WAIT}, kill flag, buffer {buf_valid, buf_instr, buf_pc}.
- Reset (clear=0 at edge): pc_q=RESET_PC, state=REQ, kill=0, buf_valid=0, buf_pc=RESET_PC. During/after reset: instr_if=NOP_INSTR, pc_if=RESET_PC, pc_plus4_if=RESET_PC+4, instr_valid_if=0, imem_req_valid=0 while clear=0. Reset mid-fetch drops any outstanding request; a late response arriving in REQ is ignored.
- consume = buf_valid & ~stall & ~redirect (IF/ID latches buffer at this edge).
- Outputs combinational from buffer: instr_if = buf_valid ? buf_instr : NOP_INSTR; pc_if=buf_pc; pc_plus4_if=buf_pc+4 (wraps 32'hFFFF_FFFC -> 0); instr_valid_if=buf_valid.
- imem_req_valid = (state==REQ) & (~buf_valid | consume) & ~redirect & clear; imem_req_addr = pc_q.
- REQ: req_valid & req_ready -> WAIT. Otherwise remain.
- WAIT: imem_req_valid=0. On resp_valid: if kill -> discard, kill<=0, ->REQ; else buf_instr<=resp_data, buf_pc<=pc_q, buf_valid<=1, pc_q<=pc_q+4, ->REQ. Without resp: remain.
- Buffer: cleared on consume unless refilled same edge; resp capture and consume in same cycle never collide (request only issued when buffer free/freeing).
- Redirect (priority over stall and resp): pc_q<=redirect_pc, buf_valid<=0 (outputs NOP next cycle). In WAIT without resp -> kill<=1, stay WAIT. In WAIT with resp -> drop resp, ->REQ, kill<=0. In REQ -> stay REQ (no request issued that cycle).
- redirect & stall together: redirect wins, buffer flushed.
- Single outstanding fetch; with zero-wait memory (ready=1, resp next cycle) throughput = 1 instruction per 2 cycles.
- redirect_pc[1:0] assumed 0 by contract; passed through unchanged.

Test Plan:
- Reset then ready=1, 1-cycle memory returning addr-based data -> req addrs 0x0,0x4,0x8; pc_if 0x0,0x4,0x8 with pc_plus4_if 0x4,0x8,0xC; instr_valid_if=1 on each.
- Hold stall=1 for 5 cycles with buffer full (pc_if=0x8) -> outputs frozen at 0x8, imem_req_valid=0; release -> next req addr 0xC.
- Redirect to 0x100 while in WAIT (resp 2 cycles later) -> stale resp discarded, next req addr 0x100, pc_if=0x100 on capture; no instruction from old PC ever valid.
- Redirect to 0x200 in same cycle as resp_valid and stall=1 -> buffer flushed (instr_if=NOP_INSTR, valid=0), next req addr 0x200.
- imem_req_ready=0 for 4 cycles -> imem_req_valid held 1 with stable addr; no state change until accept.
- Redirect to 0xFFFF_FFFC -> pc_plus4_if=0x0000_0000, next req addr 0x0000_0000; clear=0 mid-WAIT -> outputs to reset values, late resp ignored.
